// File: rtl/sram_mem_ctrl.sv
// -----------------------------------------------------------------------------
// sram_mem_ctrl
//   Bridges a pipeline MEM stage to an asynchronous SRAM. One pipeline word is
//   moved as BEATS little-endian SRAM beats. Each beat lasts WAIT_STATES+1
//   cycles. The pipeline is frozen (ready low) for the whole transfer.
//
//   The request cycle is also the first bus cycle. The SRAM strobes, address
//   and data for that cycle come straight from the live request inputs. Later
//   cycles use the latched copies. This keeps ready low for exactly
//   BEATS*(WAIT_STATES+1) cycles. It also makes the last beat's data valid in
//   the cycle ready rises.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous reset, active low
//   mem_read   : load request
//   mem_write  : store request (wins over mem_read)
//   addr       : byte address
//   wdata      : store data
//   rdata      : load data, held until the next read completes
//   ready      : high when no transfer is pending
//   SRAM_ADDR  : SRAM half-word address
//   SRAM_DQ    : SRAM data bus (tri-stated except during write beats)
//   SRAM_*_N   : active-low SRAM strobes
// -----------------------------------------------------------------------------
module sram_mem_ctrl #(
    parameter int WORD_WIDTH  = 32,
    parameter int SRAM_DATA_W = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_STATES = 5,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [WORD_WIDTH-1:0]  addr,
    input  logic [WORD_WIDTH-1:0]  wdata,
    output logic [WORD_WIDTH-1:0]  rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam int BEATS      = WORD_WIDTH / SRAM_DATA_W;
    localparam int BYTE_SHIFT = $clog2(WORD_WIDTH / 8);
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAIT_W     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int CALC_W     = (SRAM_ADDR_W > WORD_WIDTH) ? SRAM_ADDR_W : WORD_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [BEAT_W-1:0]       beat_reg, beat_next;
    logic [WAIT_W-1:0]       wait_reg, wait_next;
    logic [WORD_WIDTH-1:0]   addr_reg, wdata_reg;
    logic                    write_reg;

    logic                    request, start, active, cur_write;
    logic                    last_wait, last_cycle, sample;
    logic [WORD_WIDTH-1:0]   cur_addr, cur_wdata, offset, word_idx;
    logic [CALC_W-1:0]       lin_addr;
    logic [SRAM_DATA_W-1:0]  wdata_beats [BEATS];
    logic [SRAM_DATA_W-1:0]  rdata_beats [BEATS];

    // Control and next-state logic
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        wait_next  = wait_reg;

        request    = mem_read | mem_write;
        start      = (state_reg == IDLE) && request;
        ready      = !(start || (state_reg == ACCESS));
        // The bus goes quiet in the reset cycle, so an aborted transfer
        // produces no further strobes.
        active     = rst && (start || (state_reg == ACCESS));
        cur_write  = (state_reg == ACCESS) ? write_reg : mem_write;
        cur_addr   = (state_reg == ACCESS) ? addr_reg  : addr;
        cur_wdata  = (state_reg == ACCESS) ? wdata_reg : wdata;
        last_wait  = (wait_reg == WAIT_W'(WAIT_STATES));
        last_cycle = last_wait && (beat_reg == BEAT_W'(BEATS - 1));

        case (state_reg)
            IDLE, ACCESS: begin
                if (start || (state_reg == ACCESS)) begin
                    if (last_cycle) begin
                        state_next = DONE;
                        beat_next  = '0;
                        wait_next  = '0;
                    end else begin
                        state_next = ACCESS;
                        if (last_wait) begin
                            wait_next = '0;
                            beat_next = beat_reg + BEAT_W'(1);
                        end else begin
                            wait_next = wait_reg + WAIT_W'(1);
                        end
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Word index scaled by beats. Out-of-range addresses wrap modulo the
    // SRAM address space.
    always_comb begin
        offset    = cur_addr - WORD_WIDTH'(BASE_ADDR);
        word_idx  = offset >> BYTE_SHIFT;
        lin_addr  = CALC_W'(word_idx) * CALC_W'(BEATS) + CALC_W'(beat_reg);
        SRAM_ADDR = active ? lin_addr[SRAM_ADDR_W-1:0] : '0;
    end

    // With WAIT_STATES=0 a write beat has only its "last" cycle, so WE_N
    // never falls. This is inherent to the strobe shape.
    assign SRAM_OE_N = !(active && !cur_write);
    assign SRAM_WE_N = !(active && cur_write && !last_wait);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign sample    = active && !cur_write && last_wait;

    always_comb begin
        for (int i = 0; i < BEATS; i++) begin
            wdata_beats[i] = cur_wdata[i*SRAM_DATA_W +: SRAM_DATA_W];
        end
    end

    assign SRAM_DQ = (active && cur_write) ? wdata_beats[beat_reg] : {SRAM_DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            wait_reg  <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            write_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            wait_reg  <= wait_next;
            if (start) begin
                addr_reg  <= addr;
                wdata_reg <= wdata;
                write_reg <= mem_write;
            end
        end
    end

    // One capture register per beat slice; writes never touch them.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_rd_beat
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rdata_beats[gi] <= '0;
                end else if (sample && (beat_reg == BEAT_W'(gi))) begin
                    rdata_beats[gi] <= SRAM_DQ;
                end
            end
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < BEATS; i++) begin
            rdata[i*SRAM_DATA_W +: SRAM_DATA_W] = rdata_beats[i];
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
module tb_sram_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst, mem_read, mem_write, ready;
    logic [31:0] addr, wdata, rdata;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    sram_mem_ctrl u_dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(we_n),
        .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    // 64-bit, zero-wait-state instance
    logic        mem_read2, mem_write2, ready2;
    logic [63:0] addr2, wdata2, rdata2;
    logic [17:0] sram_addr2;
    wire  [15:0] sram_dq2;
    logic        we_n2, oe_n2, ce_n2, ub_n2, lb_n2;

    sram_mem_ctrl #(.WORD_WIDTH(64), .WAIT_STATES(0)) u_dut64 (
        .clk(clk), .rst(rst), .mem_read(mem_read2), .mem_write(mem_write2),
        .addr(addr2), .wdata(wdata2), .rdata(rdata2), .ready(ready2),
        .SRAM_ADDR(sram_addr2), .SRAM_DQ(sram_dq2), .SRAM_WE_N(we_n2),
        .SRAM_OE_N(oe_n2), .SRAM_CE_N(ce_n2), .SRAM_UB_N(ub_n2), .SRAM_LB_N(lb_n2)
    );

    // SRAM models: asynchronous read while OE_N low, write on clock while WE_N low
    logic [15:0] sram_mem  [0:1023];
    logic [15:0] sram_mem2 [0:63];
    assign sram_dq  = (!oe_n && we_n)   ? sram_mem[sram_addr[9:0]]   : 16'hzzzz;
    assign sram_dq2 = (!oe_n2 && we_n2) ? sram_mem2[sram_addr2[5:0]] : 16'hzzzz;
    always @(posedge clk) if (!we_n && !ce_n) sram_mem[sram_addr[9:0]] <= sram_dq;

    // Reference model: expected SRAM contents and last loaded word
    logic [15:0] ref_mem [0:1023];
    logic [31:0] last_rdata;
    int checks = 0, failures = 0, txn_no = 0;

    function automatic logic [15:0] init_val(input int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    // word index = (addr - 1024) >> 2; two beats per word; wrap to 18 bits
    function automatic logic [17:0] exp_addr(input logic [31:0] a, input int k);
        logic [31:0] w;
        w = (a - 32'd1024) >> 2;
        return 18'(w * 2 + k);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [17:0] x0, x1;
        x0 = exp_addr(a, 0);
        x1 = exp_addr(a, 1);
        return {ref_mem[x1[9:0]], ref_mem[x0[9:0]]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    endtask

    // One full transfer on the default instance: 12 frozen cycles, then DONE.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [17:0] a0,
                           input logic [31:0] exp_rd, input bit scramble);
        logic [17:0] xa;
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        for (int c = 0; c < 12; c++) begin
            int bt, wt;
            bt = c / 6;
            wt = c % 6;
            @(negedge clk);
            chk("ready_low", 64'(ready), 64'(0));
            chk("sram_addr", 64'(sram_addr), 64'(a0 + 18'(bt)));
            chk("oe_n", 64'(oe_n), 64'(wr));
            chk("we_n", 64'(we_n), 64'(!(wr && wt < 5)));
            if (wr) chk("dq_write", 64'(sram_dq), 64'(d[bt*16 +: 16]));
            @(posedge clk); #1;
            if (scramble) begin
                mem_read  = 1'($urandom_range(0, 1));
                mem_write = 1'($urandom_range(0, 1));
                addr      = $urandom;
                wdata     = $urandom;
            end else begin
                clear_inputs();
            end
        end
        @(negedge clk);
        chk("ready_done", 64'(ready), 64'(1));
        chk("rdata", 64'(rdata), 64'(exp_rd));
        @(posedge clk); #1;
        clear_inputs();
        if (wr) begin
            for (int k = 0; k < 2; k++) begin
                xa = exp_addr(a, k);
                ref_mem[xa[9:0]] = d[k*16 +: 16];
            end
        end else begin
            last_rdata = exp_rd;
        end
        $display("txn %0d rd=%0b wr=%0b addr=%h wdata=%h rdata=%h", txn_no, rd, wr, a, d, rdata);
        txn_no++;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [17:0] a0;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp64;
        logic [31:0] a, d, er;
        bit          rd, wr;
        int          op;

        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = init_val(i);
            ref_mem[i]  = init_val(i);
        end
        for (int i = 0; i < 64; i++) sram_mem2[i] = init_val(i);

        vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4,       32'h00000000};
        vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        18'd4,       32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 18'd0,       32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd1027, 32'h0,        18'd0,       32'h12345678};
        vecs[4] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE,   32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 32'd1020, 32'h0,        18'h3FFFE,   32'hCAFEF00D};
        vecs[6] = '{1'b0, 1'b1, 32'd1036, 32'h0BADC0DE, 18'd6,       32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 32'd1032, 32'h0,        18'd4,       32'hDEADBEEF};
        vecs[8] = '{1'b1, 1'b0, 32'd1036, 32'h0,        18'd6,       32'h0BADC0DE};

        rst = 1'b0;
        clear_inputs();
        mem_read2 = 1'b0; mem_write2 = 1'b0; addr2 = '0; wdata2 = '0;
        last_rdata = '0;
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_we_n", 64'(we_n), 64'(1));
        chk("rst_oe_n", 64'(oe_n), 64'(1));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_sram_addr", 64'(sram_addr), 64'(0));
        chk("rst_strobes", 64'({ce_n, ub_n, lb_n}), 64'(0));
        chk("rst_ready2", 64'(ready2), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;

        // ready is combinational on the request in IDLE
        @(negedge clk);
        mem_read = 1'b1;
        #1;
        chk("idle_ready_comb", 64'(ready), 64'(0));
        mem_read = 1'b0;
        #1;
        chk("idle_ready_quiet", 64'(ready), 64'(1));
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].a0, vecs[i].exp_rd, 1'b0);
        end

        // Read held across DONE: two transfers, one ready-high gap, no third
        er = ref_read(32'd1032);
        mem_read = 1'b1; addr = 32'd1032;
        for (int t = 0; t < 2; t++) begin
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                chk("hold_ready_low", 64'(ready), 64'(0));
                chk("hold_oe_n", 64'(oe_n), 64'(0));
                @(posedge clk); #1;
                if (t == 1) mem_read = 1'b0;
            end
            @(negedge clk);
            chk("hold_ready_done", 64'(ready), 64'(1));
            chk("hold_rdata", 64'(rdata), 64'(er));
            @(posedge clk); #1;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_no_third", 64'({ready, oe_n}), 64'(2'b11));
            @(posedge clk); #1;
        end
        last_rdata = er;
        $display("txn %0d held read addr=%h rdata=%h", txn_no, 32'd1032, rdata);
        txn_no++;

        // Reset in cycle 3 of a write
        mem_write = 1'b1; addr = 32'd1040; wdata = 32'h55AA33CC;
        @(negedge clk);
        chk("abort_we_low", 64'(we_n), 64'(0));
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we_n", 64'(we_n), 64'(1));
        chk("abort_oe_n", 64'(oe_n), 64'(1));
        chk("abort_ready", 64'(ready), 64'(1));
        chk("abort_rdata", 64'(rdata), 64'(0));
        chk("abort_sram_addr", 64'(sram_addr), 64'(0));
        chk("abort_beat0", 64'(sram_mem[8]), 64'(16'h33CC));
        ref_mem[8] = 16'h33CC;
        last_rdata = '0;
        $display("txn %0d aborted write addr=%h", txn_no, 32'd1040);
        txn_no++;
        @(posedge clk); #1;
        run_txn(1'b1, 1'b0, 32'd1040, 32'h0, exp_addr(32'd1040, 0), ref_read(32'd1040), 1'b0);

        // 64-bit, zero wait states: four one-cycle beats
        mem_read2 = 1'b1; addr2 = 64'd1064;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("w64_ready_low", 64'(ready2), 64'(0));
            chk("w64_sram_addr", 64'(sram_addr2), 64'(20 + c));
            chk("w64_oe_n", 64'(oe_n2), 64'(0));
            @(posedge clk); #1;
            mem_read2 = 1'b0;
        end
        @(negedge clk);
        exp64 = {init_val(23), init_val(22), init_val(21), init_val(20)};
        chk("w64_ready_done", 64'(ready2), 64'(1));
        chk("w64_rdata", rdata2, exp64);
        $display("txn %0d w64 read addr=%h rdata=%h", txn_no, addr2, rdata2);
        txn_no++;
        @(posedge clk); #1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 2));
            rd = (op != 1);
            wr = (op != 0);
            a  = 32'd1024 + 32'(4 * $urandom_range(0, 300)) + 32'($urandom_range(0, 3));
            d  = $urandom;
            er = wr ? last_rdata : ref_read(a);
            run_txn(rd, wr, a, d, exp_addr(a, 0), er, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_mem_ctrl.md
SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

Interface
REQ-001 Parameter WORD_WIDTH, default 32: pipeline data width; SHALL be an integer multiple of SRAM_DATA_W.
REQ-002 Parameter SRAM_DATA_W, default 16: SRAM data bus width.
REQ-003 Parameter SRAM_ADDR_W, default 18: SRAM address width.
REQ-004 Parameter WAIT_STATES, default 5: extra cycles per SRAM beat; legal range 0..15.
REQ-005 Parameter BASE_ADDR, default 1024: byte address mapped to SRAM word 0.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-008 mem_read  input  1  read request from the EXE/MEM pipeline register.
REQ-009 mem_write  input  1  write request from the EXE/MEM pipeline register.
REQ-010 addr  input  WORD_WIDTH  byte address (ALU result).
REQ-011 wdata  input  WORD_WIDTH  store data (Rm value).
REQ-012 rdata  output  WORD_WIDTH  load data; valid in the cycle ready rises.
REQ-013 ready  output  1  high = no transfer pending; pipeline freeze = ~ready.
REQ-014 SRAM_ADDR  output  SRAM_ADDR_W  SRAM half-word address.
REQ-015 SRAM_DQ  inout  SRAM_DATA_W  SRAM data bus.
REQ-016 SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low SRAM strobes.

Function
REQ-017 BEATS = WORD_WIDTH/SRAM_DATA_W; each beat occupies WAIT_STATES+1 cycles.
REQ-018 States: IDLE, ACCESS, DONE.
REQ-019 IDLE: ready is combinationally low in any cycle mem_read or mem_write is high, else high. A request latches addr, wdata, and direction, then goes to ACCESS.
REQ-020 ACCESS: beat counter 0..BEATS-1 and wait counter 0..WAIT_STATES; after the last wait cycle of the last beat, go to DONE.
REQ-021 ready SHALL be low for exactly BEATS*(WAIT_STATES+1) consecutive cycles, starting with the request cycle.
REQ-022 DONE: ready high for exactly one cycle, then IDLE; a request present in DONE SHALL NOT start a transfer.
REQ-023 A request present in the first IDLE cycle after DONE starts a new transfer; back-to-back transfers are therefore separated by one ready-high cycle.
REQ-024 Address mapping: word index = (addr - BASE_ADDR) >> log2(WORD_WIDTH/8); SRAM_ADDR = word index*BEATS + beat, truncated modulo 2^SRAM_ADDR_W (wrap-around, no error).
REQ-025 Low byte-offset bits of addr are ignored; only word-aligned access is supported.
REQ-026 Beat ordering is little-endian: beat k carries bits [k*SRAM_DATA_W +: SRAM_DATA_W].
REQ-027 Read: SRAM_OE_N low throughout every read beat. SRAM_DQ is sampled into rdata beat-k slice on that beat's last wait cycle.
REQ-028 rdata holds its value until the next read completes; writes SHALL NOT alter rdata.
REQ-029 Write: SRAM_DQ is driven with the beat slice of the latched wdata for the whole beat. SRAM_WE_N is low for all cycles of the beat except the last, then high.
REQ-030 Outside write beats, SRAM_DQ SHALL be high-impedance.
REQ-031 SRAM_CE_N, SRAM_UB_N, SRAM_LB_N are constant 0.
REQ-032 Outside ACCESS, SRAM_WE_N = 1 and SRAM_OE_N = 1.
REQ-033 If mem_read and mem_write are both high, the transfer is a write.
REQ-034 Inputs changing during ACCESS SHALL have no effect; latched values are used.

Reset
REQ-035 rst low at a clock edge forces: IDLE, counters 0, rdata 0, SRAM_ADDR 0, SRAM_WE_N 1, SRAM_OE_N 1, SRAM_DQ high-impedance.
REQ-036 Reset applied mid-transfer aborts it; no further SRAM strobes occur.
REQ-037 After reset, ready follows REQ-019.

Verification
REQ-038 Defaults; write addr 1032, wdata 0xDEADBEEF -> ready low 12 cycles; SRAM_ADDR 4 with DQ 0xBEEF, then 5 with DQ 0xDEAD; WE_N low 5 cycles per beat; ready high 1 cycle.
REQ-039 Then read addr 1032, SRAM model returning the stored data -> rdata 0xDEADBEEF when ready rises; OE_N low 12 cycles; DQ never driven by the DUT.
REQ-040 WAIT_STATES=0, WORD_WIDTH=64: read -> ready low exactly 4 cycles; SRAM_ADDR steps base, +1, +2, +3 one per cycle.
REQ-041 mem_read held high across DONE -> exactly one ready-high cycle between two full-length transfers; no third transfer starts.
REQ-042 mem_read and mem_write both high, addr 1024 -> write beats at SRAM_ADDR 0 and 1; OE_N stays 1.
REQ-043 rst low in cycle 3 of a write -> next cycle WE_N 1, DQ high-impedance, ready 1 (requests low), rdata 0.
